cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 43 ++++
 rtl/cdb_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if -- bundles the two result-request channels and the
// common data bus broadcast of the CDB arbiter.
//
// Signals (directions seen from the arbiter, i.e. the slave modport):
//   ALU_sgn, ALU_name, ALU_value : in  ALU result request {tag, value}
//   ALU_rdy                      : out ALU queue can take a request this cycle
//   LSB_sgn, LSB_name, LSB_value : in  load/store result request {tag, value}
//   LSB_rdy                      : out LSB queue can take a request this cycle
//   CDB_sgn, CDB_name, CDB_value : out registered broadcast (sgn = valid pulse)
//   CDB_src                      : out source of the broadcast, 0 = ALU, 1 = LSB
// The master modport is the requester/listener side (execution units, ROB).
interface cdb_arbiter_if #(
  parameter int ROB_W = 4
);
  logic             ALU_sgn;
  logic [ROB_W-1:0] ALU_name;
  logic [31:0]      ALU_value;
  logic             ALU_rdy;

  logic             LSB_sgn;
  logic [ROB_W-1:0] LSB_name;
  logic [31:0]      LSB_value;
  logic             LSB_rdy;

  logic             CDB_sgn;
  logic [ROB_W-1:0] CDB_name;
  logic [31:0]      CDB_value;
  logic             CDB_src;

  modport master (
    output ALU_sgn, ALU_name, ALU_value,
    output LSB_sgn, LSB_name, LSB_value,
    input  ALU_rdy, LSB_rdy,
    input  CDB_sgn, CDB_name, CDB_value, CDB_src
  );

  modport slave (
    input  ALU_sgn, ALU_name, ALU_value,
    input  LSB_sgn, LSB_name, LSB_value,
    output ALU_rdy, LSB_rdy,
    output CDB_sgn, CDB_name, CDB_value, CDB_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- common data bus arbiter. The ALU and the LSB each own a
// 2-entry request FIFO; every enabled cycle at most one queue head is popped
// and broadcast on the registered CDB for exactly one cycle.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous active-low reset
//   rdy   : global enable; when low every register holds (clear included)
//   clear : misprediction flush, empties both queues, no broadcast
//   bus   : cdb_arbiter_if.slave -- request channels, X_rdy, CDB outputs
//
// Configuration macro CDB_RR_EN:
//   defined   -> ties between two non-empty queues go round-robin
//                (the source other than last_grant wins)
//   undefined -> ties always go to the LSB; last_grant is still tracked
module cdb_arbiter #(
  parameter int ROB_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  cdb_arbiter_if.slave bus
);

  // Request queue storage (data only, never reset) and control state.
  logic [ROB_W-1:0] alu_name_q  [2];
  logic [31:0]      alu_value_q [2];
  logic [ROB_W-1:0] lsb_name_q  [2];
  logic [31:0]      lsb_value_q [2];
  logic [1:0]       alu_cnt, lsb_cnt;
  logic             alu_rp, alu_wp, lsb_rp, lsb_wp;
  logic             last_grant;

  logic             alu_rdy, lsb_rdy;
  logic             alu_ne, lsb_ne;
  logic             alu_push, lsb_push, alu_pop, lsb_pop;
  logic             tie_lsb, pick_lsb, grant;
  logic [ROB_W-1:0] head_name;
  logic [31:0]      head_value;

  // Broadcast register stage.
  logic             vld_p1;
  logic [ROB_W-1:0] name_p1;
  logic [31:0]      value_p1;
  logic             src_p1;

  assign alu_rdy = (alu_cnt < 2'd2);
  assign lsb_rdy = (lsb_cnt < 2'd2);
  assign alu_ne  = (alu_cnt != 2'd0);
  assign lsb_ne  = (lsb_cnt != 2'd0);

  // A request while the queue is full is simply not taken; the requester
  // keeps presenting it until X_rdy returns.
  assign alu_push = bus.ALU_sgn & alu_rdy & rdy & ~clear;
  assign lsb_push = bus.LSB_sgn & lsb_rdy & rdy & ~clear;

`ifdef CDB_RR_EN
  assign tie_lsb = ~last_grant;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign tie_lsb = 1'b1;
`endif

  // Arbitration looks only at the pre-edge counts, so a request pushed this
  // edge is never broadcast before the following edge.
  assign pick_lsb = lsb_ne & (~alu_ne | tie_lsb);
  assign grant    = alu_ne | lsb_ne;
  assign alu_pop  = rdy & ~clear & alu_ne & ~pick_lsb;
  assign lsb_pop  = rdy & ~clear & pick_lsb;

  assign head_name  = pick_lsb ? lsb_name_q[lsb_rp]  : alu_name_q[alu_rp];
  assign head_value = pick_lsb ? lsb_value_q[lsb_rp] : alu_value_q[alu_rp];

  // Queue storage: written on an accepted push only.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_name_q[alu_wp]  <= bus.ALU_name;
      alu_value_q[alu_wp] <= bus.ALU_value;
    end
    if (lsb_push) begin
      lsb_name_q[lsb_wp]  <= bus.LSB_name;
      lsb_value_q[lsb_wp] <= bus.LSB_value;
    end
  end

  // Queue control. A push and a pop on one queue at the same edge leave the
  // count unchanged; that only arises with one entry held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_cnt <= 2'd0;
      alu_rp  <= 1'b0;
      alu_wp  <= 1'b0;
      lsb_cnt <= 2'd0;
      lsb_rp  <= 1'b0;
      lsb_wp  <= 1'b0;
    end else if (rdy) begin
      if (clear) begin
        alu_cnt <= 2'd0;
        alu_rp  <= 1'b0;
        alu_wp  <= 1'b0;
        lsb_cnt <= 2'd0;
        lsb_rp  <= 1'b0;
        lsb_wp  <= 1'b0;
      end else begin
        if (alu_push) alu_wp <= ~alu_wp;
        if (alu_pop)  alu_rp <= ~alu_rp;
        if (lsb_push) lsb_wp <= ~lsb_wp;
        if (lsb_pop)  lsb_rp <= ~lsb_rp;
        alu_cnt <= alu_cnt + {1'b0, alu_push} - {1'b0, alu_pop};
        lsb_cnt <= lsb_cnt + {1'b0, lsb_push} - {1'b0, lsb_pop};
      end
    end
  end

  // ---- stage p1: queue head -> registered CDB broadcast ----
  // last_grant resets to LSB so the first tie under round-robin goes to ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      name_p1    <= '0;
      value_p1   <= '0;
      src_p1     <= 1'b0;
      last_grant <= 1'b1;
    end else if (rdy) begin
      if (clear) begin
        vld_p1     <= 1'b0;
        last_grant <= 1'b1;
      end else if (grant) begin
        vld_p1     <= 1'b1;
        name_p1    <= head_name;
        value_p1   <= head_value;
        src_p1     <= pick_lsb;
        last_grant <= pick_lsb;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.ALU_rdy   = alu_rdy;
  assign bus.LSB_rdy   = lsb_rdy;
  assign bus.CDB_sgn   = vld_p1;
  assign bus.CDB_name  = name_p1;
  assign bus.CDB_value = value_p1;
  assign bus.CDB_src   = src_p1;

endmodule
